// File: rtl/radix_4_bfly_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : radix_4_bfly_pipe                                          |
// | Description : Pipelined radix-4 NTT/INTT butterfly mod Q with global     |
// |               valid/ready advance. Optional INV4 scaling stage enabled   |
// |               by defining RADIX4_BFLY_SCALE_EN.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module radix_4_bfly_pipe #(
    parameter int unsigned LOGQ = 17,
    parameter int unsigned Q    = 65537,
    parameter int unsigned W4   = 256
`ifdef RADIX4_BFLY_SCALE_EN
    ,
    parameter int unsigned INV4 = 49153
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_mode,
    input  logic [LOGQ-1:0] in_a,
    input  logic [LOGQ-1:0] in_b,
    input  logic [LOGQ-1:0] in_c,
    input  logic [LOGQ-1:0] in_d,
    input  logic [LOGQ-1:0] tw1,
    input  logic [LOGQ-1:0] tw2,
    input  logic [LOGQ-1:0] tw3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] out_a,
    output logic [LOGQ-1:0] out_b,
    output logic [LOGQ-1:0] out_c,
    output logic [LOGQ-1:0] out_d,
    output logic            out_mode
);

    typedef logic [LOGQ-1:0] coef_t;

    localparam logic [LOGQ:0]     c_q_add = (LOGQ+1)'(Q);
    localparam logic [2*LOGQ-1:0] c_q_mul = (2*LOGQ)'(Q);
    localparam coef_t             c_w4    = coef_t'(W4);
`ifdef RADIX4_BFLY_SCALE_EN
    localparam coef_t             c_inv4  = coef_t'(INV4);
`endif

    function automatic coef_t add_mod(input coef_t x, input coef_t y);
        logic [LOGQ:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= c_q_add) s = s - c_q_add;
        return coef_t'(s);
    endfunction

    function automatic coef_t sub_mod(input coef_t x, input coef_t y);
        logic [LOGQ:0] s;
        if (x >= y) s = {1'b0, x} - {1'b0, y};
        else        s = {1'b0, x} + c_q_add - {1'b0, y};
        return coef_t'(s);
    endfunction

    function automatic coef_t mul_mod(input coef_t x, input coef_t y);
        logic [2*LOGQ-1:0] p;
        p = {{LOGQ{1'b0}}, x} * {{LOGQ{1'b0}}, y};
        return coef_t'(p % c_q_mul);
    endfunction

    logic                 w_adv;
    logic [3:0][LOGQ-1:0] w_in_x;
    logic [2:0][LOGQ-1:0] w_in_tw;
    logic [3:0][LOGQ-1:0] w_s1_x, w_s2_x, w_s3_x, w_s4_x;

    logic                 r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid;
    logic                 r_s1_mode,  r_s2_mode,  r_s3_mode,  r_s4_mode;
    logic [3:0][LOGQ-1:0] r_s1_x, r_s2_x, r_s3_x, r_s4_x;
    logic [2:0][LOGQ-1:0] r_s1_tw, r_s2_tw, r_s3_tw;

    assign w_in_x  = {in_d, in_c, in_b, in_a};
    assign w_in_tw = {tw3, tw2, tw1};

    // Whole pipe moves in lockstep; only a stalled output beat freezes it.
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // S1: twiddle pre-multiply for forward beats
    assign w_s1_x[0] = w_in_x[0];
    generate
        for (genvar i = 1; i < 4; i++) begin : g_s1_lane
            assign w_s1_x[i] = in_mode ? w_in_x[i] : mul_mod(w_in_x[i], w_in_tw[i-1]);
        end
    endgenerate

    // S2 lanes hold {p, m, q, r}
    assign w_s2_x[0] = add_mod(r_s1_x[0], r_s1_x[2]);
    assign w_s2_x[1] = sub_mod(r_s1_x[0], r_s1_x[2]);
    assign w_s2_x[2] = add_mod(r_s1_x[1], r_s1_x[3]);
    assign w_s2_x[3] = mul_mod(c_w4, sub_mod(r_s1_x[1], r_s1_x[3]));

    // S3: inverse swaps X1/X3 since W4^-1 = -W4
    assign w_s3_x[0] = add_mod(r_s2_x[0], r_s2_x[2]);
    assign w_s3_x[2] = sub_mod(r_s2_x[0], r_s2_x[2]);
    assign w_s3_x[1] = r_s2_mode ? sub_mod(r_s2_x[1], r_s2_x[3]) : add_mod(r_s2_x[1], r_s2_x[3]);
    assign w_s3_x[3] = r_s2_mode ? add_mod(r_s2_x[1], r_s2_x[3]) : sub_mod(r_s2_x[1], r_s2_x[3]);

    // S4: twiddle post-multiply for inverse beats
    assign w_s4_x[0] = r_s3_x[0];
    generate
        for (genvar i = 1; i < 4; i++) begin : g_s4_lane
            assign w_s4_x[i] = r_s3_mode ? mul_mod(r_s3_x[i], r_s3_tw[i-1]) : r_s3_x[i];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s4_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s2_mode  <= 1'b0;
            r_s3_mode  <= 1'b0;
            r_s4_mode  <= 1'b0;
            r_s1_x     <= '0;
            r_s2_x     <= '0;
            r_s3_x     <= '0;
            r_s4_x     <= '0;
            r_s1_tw    <= '0;
            r_s2_tw    <= '0;
            r_s3_tw    <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            r_s4_valid <= r_s3_valid;
            r_s1_mode  <= in_mode;
            r_s2_mode  <= r_s1_mode;
            r_s3_mode  <= r_s2_mode;
            r_s4_mode  <= r_s3_mode;
            r_s1_x     <= w_s1_x;
            r_s2_x     <= w_s2_x;
            r_s3_x     <= w_s3_x;
            r_s4_x     <= w_s4_x;
            r_s1_tw    <= w_in_tw;
            r_s2_tw    <= r_s1_tw;
            r_s3_tw    <= r_s2_tw;
        end
    end

`ifdef RADIX4_BFLY_SCALE_EN
    logic                 r_s5_valid, r_s5_mode;
    logic [3:0][LOGQ-1:0] r_s5_x;
    logic [3:0][LOGQ-1:0] w_s5_x;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_s5_lane
            assign w_s5_x[i] = r_s4_mode ? mul_mod(r_s4_x[i], c_inv4) : r_s4_x[i];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s5_valid <= 1'b0;
            r_s5_mode  <= 1'b0;
            r_s5_x     <= '0;
        end else if (w_adv) begin
            r_s5_valid <= r_s4_valid;
            r_s5_mode  <= r_s4_mode;
            r_s5_x     <= w_s5_x;
        end
    end

    assign out_valid = r_s5_valid;
    assign out_mode  = r_s5_mode;
    assign out_a     = r_s5_x[0];
    assign out_b     = r_s5_x[1];
    assign out_c     = r_s5_x[2];
    assign out_d     = r_s5_x[3];
`else
    assign out_valid = r_s4_valid;
    assign out_mode  = r_s4_mode;
    assign out_a     = r_s4_x[0];
    assign out_b     = r_s4_x[1];
    assign out_c     = r_s4_x[2];
    assign out_d     = r_s4_x[3];
`endif

endmodule
`default_nettype wire

// File: doc/radix_4_bfly_pipe.md
# radix_4_bfly_pipe

Pipelined, mode-switchable radix-4 butterfly processing element for the NTT/INTT datapath. It accepts one group of four coefficients and three twiddles per beat under a valid/ready handshake. It computes either the forward (DIT, twiddle pre-multiply) or inverse (DIF, twiddle post-multiply) radix-4 butterfly modulo Q. It replaces the combinational INTT-only PE in the transform core's stage loop and is intended to be instanced once per lane by the stage controller.

## Interface
- LOGQ, 17, coefficient width in bits
- Q, 65537, prime modulus; Q < 2^LOGQ
- W4, 256, primitive 4th root of unity mod Q (W4^2 ≡ −1)
- INV4, 49153, 4^−1 mod Q; used only with scaling compiled in
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  PE can accept a beat this cycle
- in_mode  in  1  0 = NTT, 1 = INTT; travels with the beat
- in_a, in_b, in_c, in_d  in  LOGQ each  coefficients, required < Q
- tw1, tw2, tw3  in  LOGQ each  twiddles for lanes b/c/d, required < Q (lane a twiddle is 1)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_a, out_b, out_c, out_d  out  LOGQ each  results, canonical [0, Q)
- out_mode  out  1  mode of the output beat

## Operation
- Stage S1 (pre-mult): NTT: b'=b·tw1, c'=c·tw2, d'=d·tw3 mod Q; INTT: pass through. Twiddles for INTT are carried in S1 registers to S4.
- Stage S2: p=a'+c', m=a'−c', q=b'+d', r=W4·(b'−d'), all mod Q.
- Stage S3: X0=p+q, X2=p−q; NTT: X1=m+r, X3=m−r; INTT: X1=m−r, X3=m+r (W4^−1 = −W4).
- Stage S4 (post-mult): INTT: X1·tw1, X2·tw2, X3·tw3 mod Q, X0 unchanged; NTT: pass through.
- All add/sub results are reduced to [0, Q) with a single conditional correction. Products are fully reduced. No intermediate value leaves [0, Q).
- Every stage register holds {valid, mode, data}. Bubbles are not collapsed.
- Global advance: adv = ~out_valid | out_ready. All stages shift when adv=1 and hold when adv=0.
- in_ready = adv (combinational). A beat is accepted when in_valid & in_ready.
- Output order equals input order. No beat is dropped or duplicated under any out_ready pattern.

## Timing
- Latency 4 cycles from an accepted beat to out_valid (5 with scaling), given no back-pressure.
- Throughput 1 beat/cycle when out_ready is held high.
- out_valid, out_* and out_mode are registered (S4/S5 outputs). in_ready is combinational from out_valid and out_ready.
- While out_valid=1 and out_ready=0: outputs and all stage contents are held stable, and in_ready=0.
- Simultaneous accept and emit in one cycle is legal and loses nothing.
- Reset (asynchronous assert, synchronous-safe deassert) clears every stage valid, data and mode register to 0. After reset, out_valid=0, out_a..out_d=0 and out_mode=0. Beats in flight at reset are discarded.
- Inputs and twiddles ≥ Q are out of contract. No checking is done.

## Configuration
- RADIX4_BFLY_SCALE_EN defined: adds stage S5. In INTT beats, S5 multiplies all four lanes by INV4, so the inverse butterfly exactly undoes the forward one. NTT beats pass S5 unchanged. Latency becomes 5 for both modes.
- Undefined: no S5. Latency is 4. INTT outputs are 4× the true inverse, and the caller scales once at transform end.

## Test plan
- NTT, tw1..3=1, (a,b,c,d)=(1,0,0,0), out_ready=1 -> after 4 cycles out=(1,1,1,1), out_mode=0.
- NTT, tw=1, (0,1,0,0) -> out=(1,256,65536,65281).
- INTT, tw=1, (1,256,65536,65281) -> out=(0,4,0,0); with RADIX4_BFLY_SCALE_EN, out=(0,1,0,0) after 5 cycles.
- NTT, all inputs and twiddles = 65536 -> out=(2,65535,65535,65535), checking wrap at the Q−1 boundary.
- Stream 8 random beats with alternating modes while out_ready toggles 1,0,0,0,1,… -> outputs match the golden model in order, in_ready=0 exactly while stalled with out_valid=1, and no loss.
- Assert rst_n low with 3 beats in flight -> out_valid=0 and outputs 0 immediately. After release, the next beat is the first emitted after its full latency.
